// File: rtl/sirali_carpici.sv
// rtl/sirali_carpici.sv - sequential shift-add multiplier, one partial product per clock, start/busy/done handshake
// Optional feature: define CARPICI_SIGNED_EN for two's-complement operands.
module sirali_carpici #(
   parameter int W     = 3,
   parameter int OUT_W = W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             start,
   input  logic [W-1:0]     sayi1,
   input  logic [W-1:0]     sayi2,
   output logic [OUT_W-1:0] sonuc,
   output logic             tasma,
   output logic             busy,
   output logic             done
);
   localparam int CW = (W > 1) ? $clog2(W) : 1;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t         state, state_nxt;
   logic [W-1:0]   mcand, mplier;
   logic [2*W-1:0] acc, acc_add, prod;
   logic [CW-1:0]  cnt;
   logic           accept, last, ovf;

   assign accept  = start && (state == IDLE || state == DONE);
   assign last    = en && (state == CALC) && (cnt == CW'(W-1));
   assign acc_add = acc + (mplier[cnt] ? ({{W{1'b0}}, mcand} << cnt) : '0);

`ifdef CARPICI_SIGNED_EN
   logic           neg;
   logic [W-1:0]   mag1, mag2;
   logic [2*W-OUT_W:0] top;

   // magnitudes fit W unsigned bits, including the most negative value
   assign mag1 = sayi1[W-1] ? (~sayi1 + 1'b1) : sayi1;
   assign mag2 = sayi2[W-1] ? (~sayi2 + 1'b1) : sayi2;
   assign prod = neg ? (~acc_add + 1'b1) : acc_add;
   assign top  = prod[2*W-1:OUT_W-1];
   assign ovf  = !((&top) || !(|top));
`else
   assign prod = acc_add;
   assign ovf  = (prod >> OUT_W) != '0;
`endif

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: if (start) state_nxt = CALC;
         CALC: begin
            busy = 1'b1;
            if (last) state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = start ? CALC : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         cnt    <= '0;
         sonuc  <= '0;
         tasma  <= 1'b0;
`ifdef CARPICI_SIGNED_EN
         neg    <= 1'b0;
`endif
      end else if (accept) begin
`ifdef CARPICI_SIGNED_EN
         mcand  <= mag1;
         mplier <= mag2;
         neg    <= sayi1[W-1] ^ sayi2[W-1];
`else
         mcand  <= sayi1;
         mplier <= sayi2;
`endif
         acc    <= '0;
         cnt    <= '0;
      end else if (state == CALC && en) begin
         acc <= acc_add;
         cnt <= cnt + 1'b1;
         if (last) begin
            sonuc <= prod[OUT_W-1:0];
            tasma <= ovf;
         end
      end
   end
endmodule

// File: tb/tb_sirali_carpici.sv
// tb/tb_sirali_carpici.sv - scoreboard bench for sirali_carpici (W=3, OUT_W=3)
module tb_sirali_carpici;
   localparam int W     = 3;
   localparam int OUT_W = 3;

   logic             clk = 1'b0;
   logic             rst, en, start;
   logic [W-1:0]     sayi1, sayi2;
   logic [OUT_W-1:0] sonuc;
   logic             tasma, busy, done;

   int               vectors     = 0;
   int               miscompares = 0;
   logic [OUT_W:0]   sb[$];
   logic [OUT_W:0]   exp_e;

   sirali_carpici #(.W(W), .OUT_W(OUT_W)) dut (
      .clk(clk), .rst(rst), .en(en), .start(start),
      .sayi1(sayi1), .sayi2(sayi2),
      .sonuc(sonuc), .tasma(tasma), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // expected {tasma, sonuc} from plain integer arithmetic
   function automatic logic [OUT_W:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
      int p;
      logic t;
      logic [31:0] pv;
`ifdef CARPICI_SIGNED_EN
      p = int'($signed(x)) * int'($signed(y));
      t = (p < -(1 << (OUT_W-1))) || (p > (1 << (OUT_W-1)) - 1);
`else
      p = int'(x) * int'(y);
      t = p >= (1 << OUT_W);
`endif
      pv = p;
      return {t, pv[OUT_W-1:0]};
   endfunction

   always @(negedge clk) begin
      if (!rst && done) begin
         check("sb_nonempty", 32'(sb.size() != 0), 1);
         if (sb.size() != 0) begin
            exp_e = sb.pop_front();
            check("sonuc", 32'(sonuc), 32'(exp_e[OUT_W-1:0]));
            check("tasma", 32'(tasma), 32'(exp_e[OUT_W]));
         end
      end
   end

   task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input bit push);
      @(posedge clk); #1;
      start = 1'b1; en = 1'b1; sayi1 = x; sayi2 = y;
      if (push) sb.push_back(model(x, y));
      @(posedge clk); #1;
      start = 1'b0;
      sayi1 = W'($urandom);
      sayi2 = W'($urandom);
   endtask

   // waits for done, stalling en and pulsing start while busy for `stall` cycles
   task automatic finish_op(input string tag, input int stall);
      int n;
      for (n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (done) break;
         if (n == 1) check({tag, "_busy"}, 32'(busy), 1);
         if (stall > 0 && n >= 2 && n < 2 + stall) begin
            en = 1'b0; start = 1'b1;
         end else begin
            en = 1'b1; start = 1'b0;
         end
      end
      check({tag, "_latency"}, n, W + 1 + stall);
      @(negedge clk);
      check({tag, "_done_pulse"}, 32'(done), 0);
      check({tag, "_busy_after"}, 32'(busy), 0);
   endtask

   initial begin
      int n, seen;
      rst = 1'b1; en = 1'b0; start = 1'b0; sayi1 = '0; sayi2 = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_sonuc", 32'(sonuc), 0);
      check("rst_tasma", 32'(tasma), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);

      issue(3'd2, 3'd3, 1'b1); finish_op("m2x3", 0);
      issue(3'd3, 3'd5, 1'b1); finish_op("m3x5", 0);
      issue(3'd7, 3'd7, 1'b1); finish_op("m7x7", 0);
      issue(3'd5, 3'd6, 1'b1); finish_op("stall", 2);
      issue(3'd0, 3'd5, 1'b1); finish_op("zero", 0);

      // back-to-back accept with start held into DONE
      issue(3'd3, 3'd2, 1'b1);
      for (n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (done) break;
      end
      check("b2b_first_latency", n, W + 1);
      start = 1'b1; sayi1 = 3'd1; sayi2 = 3'd4;
      sb.push_back(model(3'd1, 3'd4));
      @(posedge clk); #1;
      start = 1'b0; sayi1 = 3'd7; sayi2 = 3'd7;
      finish_op("b2b_second", 0);

      // reset mid-calculation aborts without a done pulse
      issue(3'd7, 3'd7, 1'b0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      seen = 0;
      repeat (W + 3) begin
         @(negedge clk);
         if (done) seen++;
      end
      check("abort_done", seen, 0);
      check("abort_sonuc", 32'(sonuc), 0);
      check("abort_busy", 32'(busy), 0);

      for (int i = 0; i < 12; i++) begin
         issue(W'($urandom), W'($urandom), 1'b1);
         finish_op("rand", $urandom_range(0, 2));
      end

      repeat (3) @(negedge clk);
      check("sb_drain", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
